// File: rtl/cpu_bus_responder_pkg.sv
// Shared definitions for the 65C02 bus responder: region codes, FSM states,
// I/O register offsets and CTRL/STATUS bit positions.
package cpu_bus_responder_pkg;

    typedef enum logic [1:0] {
        RGN_RAM = 2'd0,
        RGN_IO  = 2'd1,
        RGN_EXT = 2'd2
    } region_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXT  = 1'b1
    } state_t;

    localparam logic [7:0] OFF_RLD_LO = 8'h00;
    localparam logic [7:0] OFF_RLD_HI = 8'h01;
    localparam logic [7:0] OFF_CTRL   = 8'h02;
    localparam logic [7:0] OFF_STATUS = 8'h03;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int STAT_EXP  = 0;
    localparam int STAT_BERR = 1;

    // RAM has priority over the I/O page if the two ever overlap.
    function automatic region_t decode_region(input logic [15:0] ad,
                                              input int          ram_aw,
                                              input logic [7:0]  io_page);
        if ((32'(ad) >> ram_aw) == 32'd0) return RGN_RAM;
        if (ad[15:8] == io_page)          return RGN_IO;
        return RGN_EXT;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_timer.sv
// Interval timer on the I/O page: reload/count, EN/IE control, sticky EXP and
// BERR status bits (write-1-to-clear) and the registered IRQ output.
module bus_timer
    import cpu_bus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic       i_wr,
    input  logic [7:0] i_off,
    input  logic [7:0] i_wdata,
    input  logic       i_berr_set,
    output logic [7:0] o_rdata,
    output logic       o_irq
);

    logic [15:0] r_cnt;
    logic [7:0]  r_rld_lo;
    logic [7:0]  r_rld_hi;
    logic        r_en;
    logic        r_ie;
    logic        r_exp;
    logic        r_berr;
    logic        r_irq;
    logic        w_expire;

    assign w_expire = r_en && (r_cnt == 16'd0);
    assign o_irq    = r_irq;

    always_ff @(posedge clk) begin
        if (!RST) begin
            r_cnt    <= 16'd0;
            r_rld_lo <= 8'h00;
            r_rld_hi <= 8'h00;
            r_en     <= 1'b0;
            r_ie     <= 1'b0;
            r_exp    <= 1'b0;
            r_berr   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (r_en) begin
                r_cnt <= w_expire ? {r_rld_hi, r_rld_lo} : r_cnt - 16'd1;
            end
            // Later assignments win: a count load beats the reload, set beats W1C.
            if (i_wr) begin
                case (i_off)
                    OFF_RLD_LO: r_rld_lo <= i_wdata;
                    OFF_RLD_HI: begin
                        r_rld_hi <= i_wdata;
                        r_cnt    <= {i_wdata, r_rld_lo};
                    end
                    OFF_CTRL: begin
                        r_en <= i_wdata[CTRL_EN];
                        r_ie <= i_wdata[CTRL_IE];
                    end
                    OFF_STATUS: begin
                        if (i_wdata[STAT_EXP])  r_exp  <= 1'b0;
                        if (i_wdata[STAT_BERR]) r_berr <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (w_expire)   r_exp  <= 1'b1;
            if (i_berr_set) r_berr <= 1'b1;
            r_irq <= r_exp && r_ie;
        end
    end

    always_comb begin
        o_rdata = 8'h00;
        case (i_off)
            OFF_RLD_LO: o_rdata = r_rld_lo;
            OFF_RLD_HI: o_rdata = r_rld_hi;
            OFF_CTRL: begin
                o_rdata[CTRL_EN] = r_en;
                o_rdata[CTRL_IE] = r_ie;
            end
            OFF_STATUS: begin
                o_rdata[STAT_EXP]  = r_exp;
                o_rdata[STAT_BERR] = r_berr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 65C02 bus: decodes each access to internal RAM,
// the timer I/O page or an external req/ack port, stalling the CPU via RDY.
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int         RAM_AW  = 15,
    parameter logic [7:0] IO_PAGE = 8'hFE,
    parameter int         TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        IRQ,
    output logic        ext_req,
    output logic [15:0] ext_addr,
    output logic        ext_we,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    logic [7:0]        r_mem [0:(2**RAM_AW)-1];
    state_t            r_state;
    logic [7:0]        r_di;
    logic              r_rdy;
    logic              r_ext_req;
    logic              r_ext_we;
    logic [15:0]       r_ext_addr;
    logic [7:0]        r_ext_wdata;
    logic [WCNT_W-1:0] r_wcnt;

    region_t           w_region;
    logic              w_accept;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_io_wr;
    logic              w_timeout;
    logic [7:0]        w_tmr_rdata;
    logic              w_irq;

    assign w_region  = decode_region(AD, RAM_AW, IO_PAGE);
    assign w_accept  = RST && r_rdy && (r_state == ST_IDLE);
    assign w_ram_idx = AD[RAM_AW-1:0];
    assign w_io_wr   = w_accept && (w_region == RGN_IO) && WE;
    assign w_timeout = (r_state == ST_EXT) && !ext_ack && (r_wcnt == WCNT_LAST);

    assign DI        = r_di;
    assign RDY       = r_rdy;
    assign IRQ       = w_irq;
    assign ext_req   = r_ext_req;
    assign ext_we    = r_ext_we;
    assign ext_addr  = r_ext_addr;
    assign ext_wdata = r_ext_wdata;

    bus_timer u_timer (
        .clk        (clk),
        .RST        (RST),
        .i_wr       (w_io_wr),
        .i_off      (AD[7:0]),
        .i_wdata    (DO),
        .i_berr_set (w_timeout),
        .o_rdata    (w_tmr_rdata),
        .o_irq      (w_irq)
    );

    always_ff @(posedge clk) begin
        if (w_accept && (w_region == RGN_RAM) && WE) begin
            r_mem[w_ram_idx] <= DO;
        end
        if (w_accept && (w_region == RGN_EXT)) begin
            r_ext_addr  <= AD;
            r_ext_wdata <= DO;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_di      <= 8'h00;
            r_rdy     <= 1'b1;
            r_ext_req <= 1'b0;
            r_ext_we  <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_region)
                            RGN_RAM: if (!WE) r_di <= r_mem[w_ram_idx];
                            RGN_IO:  if (!WE) r_di <= w_tmr_rdata;
                            default: begin
                                r_state   <= ST_EXT;
                                r_ext_req <= 1'b1;
                                r_rdy     <= 1'b0;
                                r_ext_we  <= WE;
                                r_wcnt    <= '0;
                            end
                        endcase
                    end
                end
                ST_EXT: begin
                    // Ack on the final wait cycle still completes the access normally.
                    if (ext_ack || w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_ext_req <= 1'b0;
                        r_rdy     <= 1'b1;
                        if (!r_ext_we) r_di <= ext_ack ? ext_rdata : 8'hFF;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed and randomized bench for cpu_bus_responder against a simple
// behavioural model of RAM contents, timer period and external wait states.
module tb_cpu_bus_responder;

    localparam int TO = 4;

    logic        clk;
    logic        RST;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        RDY;
    logic        IRQ;
    logic        ext_req;
    logic [15:0] ext_addr;
    logic        ext_we;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_di;
    logic [7:0]  m_rld_lo;
    logic [7:0]  m_rld_hi;
    logic        m_exp;
    logic [7:0]  m_ram [logic [15:0]];
    logic [15:0] wq [$];

    cpu_bus_responder #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .RST       (RST),
        .AD        (AD),
        .DO        (DO),
        .WE        (WE),
        .DI        (DI),
        .RDY       (RDY),
        .IRQ       (IRQ),
        .ext_req   (ext_req),
        .ext_addr  (ext_addr),
        .ext_we    (ext_we),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Idle bus: a write to an unused I/O offset, which changes nothing.
    task automatic park();
        AD = 16'hFE10;
        WE = 1'b1;
        DO = 8'h00;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic [15:0] a, input logic we, input logic [7:0] d);
        AD = a;
        WE = we;
        DO = d;
        cyc();
        park();
    endtask

    task automatic io_rd(input logic [7:0] off, input logic [7:0] expv, input string tag);
        acc({8'hFE, off}, 1'b0, 8'h00);
        exp_di = expv;
        chk(tag, DI, expv);
    endtask

    task automatic ext_txn(input logic [15:0] a, input logic we, input logic [7:0] wd,
                           input int ack_at, input logic [7:0] rd);
        int   low;
        logic acked;
        acked = (ack_at >= 1) && (ack_at <= TO);
        AD = a;
        WE = we;
        DO = wd;
        cyc();
        park();
        low = 0;
        while (RDY == 1'b0 && low < 50) begin
            low++;
            chk("ext_req_hold", ext_req, 1);
            chk("ext_addr", ext_addr, a);
            chk("ext_we", ext_we, we);
            if (we) chk("ext_wdata", ext_wdata, wd);
            if (low == ack_at) begin
                ext_ack   = 1'b1;
                ext_rdata = rd;
            end
            cyc();
            ext_ack = 1'b0;
        end
        chk("ext_wait_cycles", low, acked ? ack_at : TO);
        chk("ext_req_fall", ext_req, 0);
        if (!we) exp_di = acked ? rd : 8'hFF;
        chk("ext_di", DI, exp_di);
    endtask

    initial begin
        logic        prev;
        logic [15:0] a;
        logic [7:0]  d;
        int          op;
        int          period;

        RST       = 1'b0;
        ext_ack   = 1'b0;
        ext_rdata = 8'h00;
        park();
        cyc();
        cyc();
        chk("rst_di", DI, 0);
        chk("rst_rdy", RDY, 1);
        chk("rst_irq", IRQ, 0);
        chk("rst_ext_req", ext_req, 0);
        chk("rst_ext_we", ext_we, 0);
        exp_di   = 8'h00;
        m_rld_lo = 8'h00;
        m_rld_hi = 8'h00;
        RST      = 1'b1;
        io_rd(8'h02, 8'h00, "rst_ctrl");
        io_rd(8'h03, 8'h00, "rst_status");

        // RAM write then read back
        acc(16'h0123, 1'b1, 8'h5A);
        m_ram[16'h0123] = 8'h5A;
        chk("ram_wr_di_hold", DI, exp_di);
        chk("ram_wr_rdy", RDY, 1);
        acc(16'h0123, 1'b0, 8'h00);
        exp_di = 8'h5A;
        chk("ram_rd_di", DI, exp_di);
        chk("ram_rd_rdy", RDY, 1);

        // Unused I/O offset
        acc(16'hFE00, 1'b1, 8'h99);
        m_rld_lo = 8'h99;
        acc(16'hFE10, 1'b1, 8'hFF);
        io_rd(8'h10, 8'h00, "io_unused_rd");
        io_rd(8'h00, m_rld_lo, "io_rld_lo_intact");
        io_rd(8'h02, 8'h00, "io_ctrl_intact");

        // External read acknowledged on the third request cycle
        ext_txn(16'hC000, 1'b0, 8'h00, 3, 8'h3C);

        // External read that times out, then a late ack that must be ignored
        ext_txn(16'hD000, 1'b0, 8'h00, 0, 8'h00);
        ext_ack   = 1'b1;
        ext_rdata = 8'h77;
        cyc();
        ext_ack = 1'b0;
        chk("late_ack_di", DI, exp_di);
        chk("late_ack_req", ext_req, 0);
        io_rd(8'h03, 8'h02, "berr_status");
        acc(16'hFE03, 1'b1, 8'h02);
        io_rd(8'h03, 8'h00, "berr_cleared");

        // Reset during an external wait
        AD = 16'hE000;
        WE = 1'b0;
        cyc();
        park();
        chk("rst_ext_req_up", ext_req, 1);
        cyc();
        RST = 1'b0;
        cyc();
        RST      = 1'b1;
        exp_di   = 8'h00;
        m_rld_lo = 8'h00;
        m_rld_hi = 8'h00;
        chk("rst_mid_req", ext_req, 0);
        chk("rst_mid_rdy", RDY, 1);
        chk("rst_mid_di", DI, exp_di);
        ext_ack   = 1'b1;
        ext_rdata = 8'hAB;
        cyc();
        ext_ack = 1'b0;
        chk("rst_late_ack_di", DI, exp_di);
        chk("rst_late_ack_rdy", RDY, 1);

        // Timer: period is reload+1 cycles; IRQ follows EXP one cycle later
        acc(16'hFE00, 1'b1, 8'h03);
        m_rld_lo = 8'h03;
        acc(16'hFE01, 1'b1, 8'h00);
        m_rld_hi = 8'h00;
        acc(16'hFE02, 1'b1, 8'h03);
        period = int'({m_rld_hi, m_rld_lo}) + 1;
        m_exp  = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            prev = m_exp;
            if (t == 6) begin
                AD = 16'hFE03;
                WE = 1'b1;
                DO = 8'h01;
            end
            cyc();
            park();
            if (t == 6) m_exp = 1'b0;
            if (t % period == 0) m_exp = 1'b1;
            chk($sformatf("timer_irq_t%0d", t), IRQ, prev);
        end
        acc(16'hFE02, 1'b1, 8'h00);
        acc(16'hFE03, 1'b1, 8'h03);
        cyc();
        chk("timer_irq_off", IRQ, 0);

        // Reload 0 expires every cycle, so a concurrent W1C loses
        acc(16'hFE00, 1'b1, 8'h00);
        acc(16'hFE01, 1'b1, 8'h00);
        m_rld_lo = 8'h00;
        m_rld_hi = 8'h00;
        acc(16'hFE02, 1'b1, 8'h01);
        acc(16'hFE03, 1'b1, 8'h01);
        io_rd(8'h03, 8'h01, "exp_set_wins");
        chk("irq_ie_off", IRQ, 0);
        acc(16'hFE02, 1'b1, 8'h00);
        acc(16'hFE03, 1'b1, 8'h01);
        io_rd(8'h03, 8'h00, "exp_cleared");

        // Randomized mix of RAM, reload registers and external accesses
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    a = 16'($urandom_range(0, 32767));
                    d = 8'($urandom);
                    acc(a, 1'b1, d);
                    m_ram[a] = d;
                    wq.push_back(a);
                    chk("rnd_ram_wr_di", DI, exp_di);
                end
                1: begin
                    if (wq.size() > 0) begin
                        a = wq[$urandom_range(0, wq.size() - 1)];
                        acc(a, 1'b0, 8'h00);
                        exp_di = m_ram[a];
                        chk("rnd_ram_rd", DI, exp_di);
                    end
                end
                2: begin
                    d = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) begin
                        acc(16'hFE00, 1'b1, d);
                        m_rld_lo = d;
                        io_rd(8'h00, m_rld_lo, "rnd_rld_lo");
                    end else begin
                        acc(16'hFE01, 1'b1, d);
                        m_rld_hi = d;
                        io_rd(8'h01, m_rld_hi, "rnd_rld_hi");
                    end
                end
                default: begin
                    a = 16'h8000 + 16'($urandom_range(0, 32'h7DFF));
                    ext_txn(a, 1'($urandom_range(0, 1)), 8'($urandom),
                            int'($urandom_range(0, 6)), 8'($urandom));
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
